vgacon_attr: RTL and testbench

VGACON_ATTR -- requirements
Module: vgacon_attr

---
 rtl/vgacon_attr.sv | 215 +++++++++++++++++++++
 tb/tb_vgacon_attr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vgacon_attr.sv
`default_nettype none
// ============================================================================
// vgacon_attr - attribute text-mode VGA controller with a fixed 5-clk pipeline
// Revision: 1.0
// ============================================================================
module vgacon_attr #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 16,
    parameter int SYNC_POL     = 0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [12:0] tram_addr,
    input  logic [15:0] tram_data,
    output logic [11:0] crom_addr,
    input  logic [7:0]  crom_data,
    input  logic [6:0]  scroll_row,
    input  logic [6:0]  cursor_x,
    input  logic [6:0]  cursor_y,
    input  logic        cursor_en,
    output logic [1:0]  vga_r,
    output logic [1:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_strobe
);

    localparam int   H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int   HW         = $clog2(H_TOTAL);
    localparam int   VW         = $clog2(V_TOTAL);
    localparam int   CSH        = (CHAR_H == 8) ? 3 : 4;
    localparam int   TEXT_LINES = ROWS * CHAR_H;
    localparam int   HS_START   = H_VISIBLE + H_FRONT;
    localparam int   VS_START   = V_VISIBLE + V_FRONT;
    localparam int   BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic SYNC_ACT   = (SYNC_POL != 0);

    typedef struct packed {
        logic       vis;
        logic       text;
        logic       cur;
        logic       hs;
        logic       vs;
        logic [2:0] col;
        logic [3:0] grow;
    } ctrl_t;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [6:0]    scroll_q, scroll_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          fs_q, fs_d;

    logic [12:0]   tram_addr_q, tram_addr_d;
    ctrl_t         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
    logic [15:0]   tdata_q, tdata_d;
    logic [11:0]   crom_addr_q, crom_addr_d;
    logic [7:0]    attr3_q, attr3_d, attr4_q, attr4_d;
    logic [7:0]    glyph_q, glyph_d;
    logic [1:0]    red_q, red_d, grn_q, grn_d, blu_q, blu_d;
    logic          hs_q, hs_d, vs_q, vs_d;

    logic [HW-1:0] w_cell_x;
    logic [VW-1:0] w_cell_y;
    logic [7:0]    w_sum, w_phys;
    logic [3:0]    w_grow;
    logic          w_vis, w_text, w_bit;
    logic [3:0]    w_cidx;

    // Timing counters, frame-start scroll latch and cursor blink.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
        // Latched on the edge entering (0,0) so the whole frame sees one value.
        scroll_d = scroll_q;
        if (h_d == '0 && v_d == '0 && scroll_row < 7'(ROWS)) begin
            scroll_d = scroll_row;
        end
        fs_d    = (h_d == '0) && (v_d == VW'(V_VISIBLE));
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (fs_q) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Stage 1: cell decode, scrolled text-RAM address and control word.
    always_comb begin
        w_cell_x    = h_q >> 3;
        w_cell_y    = v_q >> CSH;
        w_grow      = 4'(v_q[CSH-1:0]);
        w_vis       = (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
        w_text      = w_vis && (32'(v_q) < TEXT_LINES) && (32'(w_cell_x) < COLS);
        w_sum       = 8'(w_cell_y) + 8'(scroll_q);
        w_phys      = (w_sum >= 8'(ROWS)) ? w_sum - 8'(ROWS) : w_sum;
        tram_addr_d = 13'(w_phys * COLS) + 13'(w_cell_x);
        s1_d.vis    = w_vis;
        s1_d.text   = w_text;
        s1_d.cur    = cursor_en && blink_q && w_text
                      && (32'(w_cell_y) == 32'(cursor_y))
                      && (32'(w_cell_x) == 32'(cursor_x))
                      && (32'(w_grow) >= CHAR_H - 2);
        s1_d.hs     = (32'(h_q) >= HS_START) && (32'(h_q) < HS_START + H_SYNC);
        s1_d.vs     = (32'(v_q) >= VS_START) && (32'(v_q) < VS_START + V_SYNC);
        s1_d.col    = h_q[2:0];
        s1_d.grow   = w_grow;
    end

    // Stages 2-4: RAM capture, ROM address with attribute delay, ROM capture.
    always_comb begin
        tdata_d     = tram_data;
        s2_d        = s1_q;
        crom_addr_d = {tdata_q[7:0], s2_q.grow};
        attr3_d     = tdata_q[15:8];
        s3_d        = s2_q;
        glyph_d     = crom_data;
        attr4_d     = attr3_q;
        s4_d        = s3_q;
    end

    // Stage 5: colour select; cursor inversion is a glyph-bit flip.
    always_comb begin
        w_bit  = glyph_q[~s4_q.col] ^ s4_q.cur;
        w_cidx = w_bit ? attr4_q[3:0] : attr4_q[7:4];
        if (!s4_q.text) begin
            w_cidx = '0;
        end
        red_d = {w_cidx[2], w_cidx[2] & w_cidx[3]};
        grn_d = {w_cidx[1], w_cidx[1] & w_cidx[3]};
        blu_d = {w_cidx[0], w_cidx[0] & w_cidx[3]};
        hs_d  = s4_q.hs ? SYNC_ACT : ~SYNC_ACT;
        vs_d  = s4_q.vs ? SYNC_ACT : ~SYNC_ACT;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q         <= '0;
            v_q         <= '0;
            scroll_q    <= '0;
            blink_q     <= 1'b1;
            bcnt_q      <= '0;
            fs_q        <= 1'b0;
            tram_addr_q <= '0;
            s1_q        <= '0;
            tdata_q     <= '0;
            s2_q        <= '0;
            crom_addr_q <= '0;
            attr3_q     <= '0;
            s3_q        <= '0;
            glyph_q     <= '0;
            attr4_q     <= '0;
            s4_q        <= '0;
            red_q       <= '0;
            grn_q       <= '0;
            blu_q       <= '0;
            hs_q        <= ~SYNC_ACT;
            vs_q        <= ~SYNC_ACT;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            scroll_q    <= scroll_d;
            blink_q     <= blink_d;
            bcnt_q      <= bcnt_d;
            fs_q        <= fs_d;
            tram_addr_q <= tram_addr_d;
            s1_q        <= s1_d;
            tdata_q     <= tdata_d;
            s2_q        <= s2_d;
            crom_addr_q <= crom_addr_d;
            attr3_q     <= attr3_d;
            s3_q        <= s3_d;
            glyph_q     <= glyph_d;
            attr4_q     <= attr4_d;
            s4_q        <= s4_d;
            red_q       <= red_d;
            grn_q       <= grn_d;
            blu_q       <= blu_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign tram_addr    = tram_addr_q;
    assign crom_addr    = crom_addr_q;
    assign vga_r        = red_q;
    assign vga_g        = grn_q;
    assign vga_b        = blu_q;
    assign vga_hsync    = hs_q;
    assign vga_vsync    = vs_q;
    assign frame_strobe = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vgacon_attr.sv
`default_nettype none
// ============================================================================
// tb_vgacon_attr - per-pixel scoreboard plus per-frame vector table
// Revision: 1.0
// ============================================================================
module tb_vgacon_attr;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 2;
    localparam int CH = 16, COLS = 8, ROWS = 2, BF = 2;
    localparam int H_T = HV + HF + HS + HB;
    localparam int V_T = VV + VF + VS + VB;
    localparam int HS0 = HV + HF;
    localparam int VS0 = VV + VF;
    localparam int N_VEC = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic [12:0] tram_addr;
    logic [15:0] tram_data;
    logic [11:0] crom_addr;
    logic [7:0]  crom_data;
    logic [6:0]  scroll_row, cursor_x, cursor_y;
    logic        cursor_en;
    logic [1:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, frame_strobe;

    vgacon_attr #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CHAR_H(CH), .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF), .SYNC_POL(0)
    ) dut (
        .clk(clk), .resetn(resetn),
        .tram_addr(tram_addr), .tram_data(tram_data),
        .crom_addr(crom_addr), .crom_data(crom_data),
        .scroll_row(scroll_row), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_en(cursor_en),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    // Memories answer the registered address within the same cycle.
    function automatic logic [15:0] tram_fn(input logic [12:0] a);
        return {4'(a + 13'd1), ~a[3:0], 8'(a + 13'h41)};
    endfunction

    function automatic logic [7:0] crom_fn(input logic [11:0] a);
        int x;
        if (a == 12'h410) return 8'h80;
        x = int'(a);
        return 8'((x * 157) ^ (x >> 3));
    endfunction

    assign tram_data = tram_fn(tram_addr);
    assign crom_data = crom_fn(crom_addr);

    typedef struct {
        logic [6:0]  scroll_in;
        logic [6:0]  cx;
        logic [6:0]  cy;
        logic        cen;
        int          exp_scroll;
        bit          exp_phase;
        logic [12:0] exp_a0;
        logic [12:0] exp_a1;
    } vec_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    vec_t tbl[N_VEC];
    vec_t cfg;
    obs_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   h_m, v_m, fidx;

    function automatic obs_t exp_pix(input int h, input int v, input vec_t cf);
        obs_t       o;
        int         row, col, phys;
        logic [15:0] wd;
        logic [7:0] gl;
        logic       pbit, cur;
        logic [3:0] c;
        o    = '0;
        o.hs = !(h >= HS0 && h < HS0 + HS);
        o.vs = !(v >= VS0 && v < VS0 + VS);
        if (h < HV && v < VV && v < ROWS * CH && h / 8 < COLS) begin
            row  = v / CH;
            col  = h / 8;
            phys = (row + cf.exp_scroll) % ROWS;
            wd   = tram_fn(13'(phys * COLS + col));
            gl   = crom_fn({wd[7:0], 4'(v % CH)});
            pbit = gl[7 - (h % 8)];
            cur  = cf.cen && cf.exp_phase && (row == int'(cf.cy)) && (col == int'(cf.cx))
                   && ((v % CH) >= CH - 2);
            c    = (pbit ^ cur) ? wd[11:8] : wd[15:12];
            o.r  = {c[2], c[2] & c[3]};
            o.g  = {c[1], c[1] & c[3]};
            o.b  = {c[0], c[0] & c[3]};
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (h=%0d v=%0d)", name, act, req, h_m, v_m);
        end
    endtask

    task automatic apply(input vec_t r);
        scroll_row = r.scroll_in;
        cursor_x   = r.cx;
        cursor_y   = r.cy;
        cursor_en  = r.cen;
    endtask

    task automatic prefill();
        obs_t idle;
        idle    = '0;
        idle.hs = 1'b1;
        idle.vs = 1'b1;
        sb_q.delete();
        repeat (5) sb_q.push_back(idle);
    endtask

    // Push the expectation for the current model pixel, pop the one due now.
    task automatic sb_step();
        obs_t e, a;
        sb_q.push_back(exp_pix(h_m, v_m, cfg));
        e    = sb_q.pop_front();
        e.fs = (h_m == 0 && v_m == VV);
        a    = {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_strobe};
        chk("pix", 32'(a), 32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (h_m == H_T - 1) begin
            h_m = 0;
            if (v_m == V_T - 1) begin
                v_m = 0;
                fidx++;
                if (fidx < N_VEC) cfg = tbl[fidx];
            end else begin
                v_m++;
            end
        end else begin
            h_m++;
        end
        sb_step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t post;
        int   budget, first_hs;

        //            scroll  cx     cy     en   scr ph  a0      a1
        tbl[0] = '{7'd0, 7'd5, 7'd1, 1'b1, 0, 1, 13'd0, 13'd8};
        tbl[1] = '{7'd1, 7'd5, 7'd1, 1'b1, 1, 1, 13'd8, 13'd0};
        tbl[2] = '{7'd5, 7'd2, 7'd0, 1'b1, 1, 0, 13'd8, 13'd0};
        tbl[3] = '{7'd0, 7'd7, 7'd1, 1'b1, 0, 0, 13'd0, 13'd8};
        tbl[4] = '{7'd1, 7'd0, 7'd0, 1'b1, 1, 1, 13'd8, 13'd0};
        tbl[5] = '{7'd3, 7'd3, 7'd1, 1'b0, 1, 1, 13'd8, 13'd0};
        post   = '{7'd0, 7'd1, 7'd0, 1'b1, 0, 1, 13'd0, 13'd8};

        resetn = 1'b0;
        apply(tbl[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_tram_addr", 32'(tram_addr), 32'd0);
        chk("rst_fs", 32'(frame_strobe), 32'd0);

        @(posedge clk);
        #1;
        resetn = 1'b1;
        h_m = 0; v_m = 0; fidx = 0; cfg = tbl[0];
        prefill();
        sb_step();

        while (fidx < N_VEC) begin
            tick();
            if (v_m == VV + 1 && h_m == 0 && fidx + 1 < N_VEC) apply(tbl[fidx + 1]);
            if (fidx < N_VEC && v_m == 0 && h_m == 1)
                chk("addr_row0", 32'(tram_addr), 32'(tbl[fidx].exp_a0));
            if (fidx < N_VEC && v_m == CH && h_m == 1)
                chk("addr_row1", 32'(tram_addr), 32'(tbl[fidx].exp_a1));
            if (fidx == 0 && v_m == 0 && h_m == 5)
                chk("first_pixel", 32'({vga_r, vga_g, vga_b}), 32'h3F);
            if (fidx == 0 && v_m == 0 && h_m >= 6 && h_m <= 12)
                chk("bg_pixels", 32'({vga_r, vga_g, vga_b}), 32'h02);
        end

        // Asynchronous reset in the middle of a vsync line during hsync.
        budget = 0;
        while (!(v_m == VS0 && h_m == HS0 + 7) && budget < H_T * V_T + 10) begin
            tick();
            budget++;
        end
        chk("reach_rst_point", 32'(v_m == VS0 && h_m == HS0 + 7), 32'd1);
        chk("pre_rst_syncs", 32'({vga_hsync, vga_vsync}), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_syncs", 32'({vga_hsync, vga_vsync}), 32'd3);
        chk("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("midrst_tram", 32'(tram_addr), 32'd0);
        chk("midrst_crom", 32'(crom_addr), 32'd0);

        apply(post);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        h_m = 0; v_m = 0; fidx = 0; cfg = post;
        prefill();
        sb_step();
        first_hs = -1;
        for (int c = 1; c < H_T * V_T; c++) begin
            tick();
            if (first_hs < 0 && vga_hsync == 1'b0) first_hs = c;
            if (v_m == 0 && h_m == 1)
                chk("post_addr_row0", 32'(tram_addr), 32'(post.exp_a0));
        end
        chk("first_hsync_clk", 32'(first_hs), 32'(HS0 + 5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
